// File: rtl/fetch_pc_queue_if.sv
// Bundle between the fetch stage, the I-cache port and the ID stage.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1
// (ic_req_o/ic_ready_i, id_valid_o/id_ready_i). Valid never depends combinationally on
// ready, and the payload is held stable while valid is high without ready.
interface fetch_pc_queue_if #(
    parameter int CNT_W = 3
);
    logic             redirect_i;
    logic [31:0]      redirect_pc_i;
    logic             ic_req_o;
    logic [31:0]      ic_addr_o;
    logic             ic_ready_i;
    logic             ic_rvalid_i;
    logic [31:0]      ic_rdata_i;
    logic             id_valid_o;
    logic [31:0]      id_pc_o;
    logic [31:0]      id_inst_o;
    logic             id_adel_o;
    logic             id_ready_i;
    logic [CNT_W-1:0] fq_count_o;
    logic             dbg_state;

    modport master (
        output redirect_i, redirect_pc_i, ic_ready_i, ic_rvalid_i, ic_rdata_i, id_ready_i,
        input  ic_req_o, ic_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o,
        input  fq_count_o, dbg_state
    );

    modport slave (
        input  redirect_i, redirect_pc_i, ic_ready_i, ic_rvalid_i, ic_rdata_i, id_ready_i,
        output ic_req_o, ic_addr_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o,
        output fq_count_o, dbg_state
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// Instruction-fetch stage: owns the fetch PC, keeps one I-cache request outstanding
// and queues returned words (or AdEL markers for misaligned PCs) toward ID.
module fetch_pc_queue #(
    parameter logic [31:0] RESET_PC    = 32'hbfc00000,
    parameter int          FETCH_DEPTH = 4,
    parameter int          CNT_W       = $clog2(FETCH_DEPTH) + 1
) (
    input logic              clk,
    input logic              rst_n,
    fetch_pc_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(FETCH_DEPTH);

    typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      req_pc_q;
    logic             discard_q;
    logic             halt_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic [31:0] pc_mem   [FETCH_DEPTH];
    logic [31:0] inst_mem [FETCH_DEPTH];
    logic        adel_mem [FETCH_DEPTH];

    logic        space, can_fetch, aligned, ic_req, hs;
    logic        adel_enq, resp_enq, enq, deq, head_valid, stay_wait;
    logic [31:0] enq_pc, enq_inst;

    assign space      = count_q < CNT_W'(FETCH_DEPTH);
    assign aligned    = pc_q[1:0] == 2'b00;
    assign can_fetch  = (state_q == S_REQ) && space && !halt_q;
    // Gated by rst_n so the cache never sees a request while the stage is held in reset.
    assign ic_req     = can_fetch && aligned && rst_n;
    assign hs         = ic_req && bus.ic_ready_i;
    assign adel_enq   = can_fetch && !aligned;
    assign resp_enq   = (state_q == S_WAIT) && bus.ic_rvalid_i && !discard_q;
    assign enq        = adel_enq || resp_enq;
    assign enq_pc     = adel_enq ? pc_q : req_pc_q;
    assign enq_inst   = adel_enq ? 32'h0 : bus.ic_rdata_i;
    assign head_valid = count_q != '0;
    assign deq        = head_valid && bus.id_ready_i;

    // A redirect leaves a response outstanding if it lands on a new handshake, or in
    // S_WAIT before the response has arrived; a response arriving that same cycle is dropped.
    assign stay_wait  = hs || ((state_q == S_WAIT) && !bus.ic_rvalid_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            state_q   <= S_REQ;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
            halt_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
        end else if (bus.redirect_i) begin
            pc_q    <= bus.redirect_pc_i;
            halt_q  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            if (stay_wait) begin
                state_q   <= S_WAIT;
                discard_q <= 1'b1;
            end else begin
                state_q   <= S_REQ;
                discard_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (hs) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= S_WAIT;
                    end
                    if (adel_enq) halt_q <= 1'b1;
                end
                S_WAIT: begin
                    if (bus.ic_rvalid_i) begin
                        discard_q <= 1'b0;
                        state_q   <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !bus.redirect_i) begin
            pc_mem[wr_ptr]   <= enq_pc;
            inst_mem[wr_ptr] <= enq_inst;
            adel_mem[wr_ptr] <= adel_enq;
        end
    end

    assign bus.ic_req_o   = ic_req;
    assign bus.ic_addr_o  = pc_q;
    assign bus.id_valid_o = head_valid;
    assign bus.id_pc_o    = head_valid ? pc_mem[rd_ptr] : 32'h0;
    assign bus.id_inst_o  = head_valid ? inst_mem[rd_ptr] : 32'h0;
    assign bus.id_adel_o  = head_valid && adel_mem[rd_ptr];
    assign bus.fq_count_o = count_q;
    assign bus.dbg_state  = state_q == S_WAIT;
endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue: a 1-cycle I-cache model, an ID-side
// scoreboard of expected {pc, inst, adel} entries, and a summary line.
module tb_fetch_pc_queue;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam int          DEPTH    = 4;
    localparam int          CNT_W    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    fetch_pc_queue_if #(.CNT_W(CNT_W)) bus ();

    fetch_pc_queue #(
        .RESET_PC(RESET_PC), .FETCH_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [64:0] exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          max_cnt = 0;
    logic [31:0] hs_addr = '0;
    bit          cache_auto = 1'b0;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
        exp_q.push_back({pc, inst, adel});
    endtask

    // ---------------- driver tasks ----------------
    // One clock: observe handshakes at negedge, then update the cache model after posedge.
    task automatic step_cycle();
        logic hs;
        @(negedge clk);
        hs = bus.ic_req_o && bus.ic_ready_i;
        if (hs) hs_addr = bus.ic_addr_o;
        if (bus.id_valid_o && bus.id_ready_i && !bus.redirect_i) begin
            if (exp_q.size() == 0)
                chk("deq_extra", {bus.id_pc_o, bus.id_inst_o, bus.id_adel_o}, 65'h0);
            else
                chk("deq", {bus.id_pc_o, bus.id_inst_o, bus.id_adel_o}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (cache_auto) begin
            bus.ic_rvalid_i = hs;
            bus.ic_rdata_i  = hs ? (hs_addr ^ 32'h1234) : 32'h0;
        end
        if (int'(bus.fq_count_o) > max_cnt) max_cnt = int'(bus.fq_count_o);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        step_cycle();
        bus.redirect_i    = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) step_cycle();
        chk(tag, 65'(exp_q.size()), 65'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.redirect_i = 1'b0; bus.redirect_pc_i = '0;
        bus.ic_ready_i = 1'b0; bus.ic_rvalid_i = 1'b0; bus.ic_rdata_i = '0;
        bus.id_ready_i = 1'b0;
        step_cycle();
        step_cycle();
        chk("rst_req",   bus.ic_req_o,   0);
        chk("rst_addr",  bus.ic_addr_o,  RESET_PC);
        chk("rst_valid", bus.id_valid_o, 0);
        chk("rst_pc",    bus.id_pc_o,    0);
        chk("rst_cnt",   bus.fq_count_o, 0);

        // Sequential fetch with a 1-cycle cache and ID always ready.
        bus.ic_ready_i = 1'b1; bus.id_ready_i = 1'b1; cache_auto = 1'b1;
        exp_push(32'hbfc00000, 32'hbfc00000 ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00004, 32'hbfc00004 ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00008, 32'hbfc00008 ^ 32'h1234, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("first_req",  bus.ic_req_o,  1);
        chk("first_addr", bus.ic_addr_o, 32'hbfc00000);
        step_cycle();
        chk("wait_noreq", bus.ic_req_o,   0);
        chk("wait_empty", bus.id_valid_o, 0);
        step_cycle();
        chk("resp_valid", bus.id_valid_o, 1);
        chk("resp_pc",    bus.id_pc_o,    32'hbfc00000);
        chk("resp_inst",  bus.id_inst_o,  32'hbfc01234);
        chk("next_addr",  bus.ic_addr_o,  32'hbfc00004);
        drain("seq_drain");
        chk("seq_peak", 65'(max_cnt), 65'd1);

        // Backpressure: fetch of bfc0000c..bfc00018 fills the queue, then stops.
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) step_cycle();
        chk("full_cnt",  bus.fq_count_o, 4);
        chk("full_req",  bus.ic_req_o,   0);
        chk("full_head", bus.id_pc_o,    32'hbfc0000c);
        bus.ic_ready_i = 1'b0; bus.id_ready_i = 1'b1;
        exp_push(32'hbfc0000c, 32'hbfc0000c ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00010, 32'hbfc00010 ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00014, 32'hbfc00014 ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00018, 32'hbfc00018 ^ 32'h1234, 1'b0);
        drain("bp_drain");
        chk("bp_empty", bus.fq_count_o, 0);

        // Redirect while waiting on the response for bfc00010.
        cache_auto = 1'b0;
        redirect_to(32'hbfc00010);
        chk("rd_addr0", bus.ic_addr_o, 32'hbfc00010);
        bus.ic_ready_i = 1'b1;
        step_cycle();
        chk("rd_wait", bus.dbg_state, 1);
        redirect_to(32'h80000180);
        chk("rd_addr",    bus.ic_addr_o,  32'h80000180);
        chk("rd_pending", bus.ic_req_o,   0);
        chk("rd_novalid", bus.id_valid_o, 0);
        bus.ic_rvalid_i = 1'b1; bus.ic_rdata_i = 32'hdeadbeef;
        step_cycle();
        bus.ic_rvalid_i = 1'b0; bus.ic_rdata_i = '0;
        chk("rd_dropped", bus.id_valid_o, 0);
        chk("rd_resume",  bus.ic_req_o,   1);
        cache_auto = 1'b1;
        exp_push(32'h80000180, 32'h80000180 ^ 32'h1234, 1'b0);
        drain("rd_drain");

        // Redirect coinciding with a handshake and a dequeue.
        bus.ic_ready_i = 1'b0; bus.id_ready_i = 1'b0;
        step_cycle();
        chk("co_cnt",  bus.fq_count_o, 1);
        chk("co_head", bus.id_pc_o,    32'h80000184);
        chk("co_req",  bus.ic_req_o,   1);
        cache_auto = 1'b0;
        bus.ic_ready_i = 1'b1; bus.id_ready_i = 1'b1;
        redirect_to(32'hbfc00100);
        chk("co_valid", bus.id_valid_o, 0);
        chk("co_count", bus.fq_count_o, 0);
        chk("co_noreq", bus.ic_req_o,   0);
        bus.ic_ready_i = 1'b0;
        bus.ic_rvalid_i = 1'b1; bus.ic_rdata_i = 32'h12345678;
        step_cycle();
        bus.ic_rvalid_i = 1'b0; bus.ic_rdata_i = '0;
        chk("co_dropped", bus.id_valid_o, 0);
        chk("co_addr",    bus.ic_addr_o,  32'hbfc00100);
        chk("co_req2",    bus.ic_req_o,   1);
        cache_auto = 1'b1;

        // Misaligned PC: one AdEL entry, then halted until the next redirect.
        redirect_to(32'hbfc00002);
        chk("mis_noreq", bus.ic_req_o, 0);
        bus.id_ready_i = 1'b0;
        step_cycle();
        chk("mis_cnt",  bus.fq_count_o, 1);
        chk("mis_pc",   bus.id_pc_o,    32'hbfc00002);
        chk("mis_inst", bus.id_inst_o,  0);
        chk("mis_adel", bus.id_adel_o,  1);
        bus.ic_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step_cycle();
        chk("halt_cnt", bus.fq_count_o, 1);
        chk("halt_req", bus.ic_req_o,   0);
        exp_push(32'hbfc00002, 32'h0, 1'b1);
        bus.id_ready_i = 1'b1;
        step_cycle();
        chk("halt_empty", bus.fq_count_o, 0);
        chk("halt_req2",  bus.ic_req_o,   0);
        redirect_to(32'hbfc00380);
        chk("res_req",  bus.ic_req_o,  1);
        chk("res_addr", bus.ic_addr_o, 32'hbfc00380);
        exp_push(32'hbfc00380, 32'hbfc00380 ^ 32'h1234, 1'b0);
        exp_push(32'hbfc00384, 32'hbfc00384 ^ 32'h1234, 1'b0);
        drain("res_drain");

        // Async reset in S_WAIT with three entries queued.
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 20 && !(bus.fq_count_o == 3 && bus.dbg_state); i++) step_cycle();
        chk("ar_cnt",   bus.fq_count_o, 3);
        chk("ar_state", bus.dbg_state,  1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.id_valid_o, 0);
        chk("ar_pc",    bus.id_pc_o,    0);
        chk("ar_inst",  bus.id_inst_o,  0);
        chk("ar_adel",  bus.id_adel_o,  0);
        chk("ar_count", bus.fq_count_o, 0);
        chk("ar_req",   bus.ic_req_o,   0);
        chk("ar_addr",  bus.ic_addr_o,  RESET_PC);
        step_cycle();
        step_cycle();
        bus.id_ready_i = 1'b1;
        exp_push(32'hbfc00000, 32'hbfc00000 ^ 32'h1234, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ar_req2",  bus.ic_req_o,  1);
        chk("ar_addr2", bus.ic_addr_o, RESET_PC);
        drain("ar_drain");

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_pc_queue.md
# fetch_pc_queue

Parametrised instruction-fetch stage for the MIPS pipeline. It owns the fetch PC, issues one-outstanding-request fetches to the I-cache over a valid/ready handshake, and buffers returned instructions in a FETCH_DEPTH-entry FIFO toward ID. A redirect from the controller or branch unit discards in-flight fetch data without stalling the cache. Misaligned PCs are tagged with an AdEL exception instead of being fetched.

## Interface
- RESET_PC, 32'hbfc00000, fetch PC loaded at reset
- FETCH_DEPTH, 4, queue entries; power of two, 2..16
- CNT_W, $clog2(FETCH_DEPTH)+1, width of occupancy counter (derived)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- redirect_i  in  1  flush/branch redirect; priority over all other events
- redirect_pc_i  in  32  new fetch PC
- ic_req_o  out  1  fetch request valid
- ic_addr_o  out  32  fetch address; equals pc_q
- ic_ready_i  in  1  cache accepts request this cycle
- ic_rvalid_i  in  1  response data valid, exactly one per accepted request
- ic_rdata_i  in  32  instruction word
- id_valid_o  out  1  queue head valid
- id_pc_o  out  32  head PC
- id_inst_o  out  32  head instruction; 0 for exception entries
- id_adel_o  out  1  head carries instruction-fetch AdEL
- id_ready_i  in  1  ID consumes head when id_valid_o=1
- fq_count_o  out  CNT_W  current occupancy

## Operation
- Registers: pc_q, state (S_REQ, S_WAIT), discard_q, halt_q, req_pc_q, FIFO storage {pc, inst, adel}, wr_ptr, rd_ptr, count.
- Space condition: count < FETCH_DEPTH. A slot is reserved when a request is accepted, so enqueue never overflows.
- S_REQ, pc_q[1:0]==0, space, !halt_q: ic_req_o=1. On ic_req_o & ic_ready_i: req_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32), go to S_WAIT.
- S_REQ, pc_q[1:0]!=0, space, !halt_q: no request. Enqueue {pc_q, 0, adel=1} and set halt_q. Fetch stays stopped until redirect_i.
- S_WAIT: ic_req_o=0. On ic_rvalid_i: if !discard_q, enqueue {req_pc_q, ic_rdata_i, 0}. Clear discard_q and go to S_REQ.
- Dequeue: id_valid_o & id_ready_i advances rd_ptr. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (redirect_i=1) applies at the clock edge:
  - pc_q<=redirect_pc_i; FIFO emptied (count=0, pointers equal); halt_q<=0.
  - In S_WAIT, or in S_REQ with a handshake the same cycle: discard_q<=1, state goes or stays S_WAIT. The pending response is dropped.
  - Otherwise the state is S_REQ.
  - Redirect overrides any same-cycle enqueue, dequeue, or pc increment.
- ID is responsible for delay slots: it asserts redirect_i for a branch only after the delay-slot instruction has been dequeued.
- No combinational path from redirect_i, id_ready_i or ic_rvalid_i to ic_req_o / ic_addr_o.

## Timing
- Reset (async) values:
  - pc_q=RESET_PC, state=S_REQ, discard_q=0, halt_q=0, count=0.
  - Outputs: ic_req_o=0 while rst_n=0; id_valid_o=0, id_pc_o=0, id_inst_o=0, id_adel_o=0, fq_count_o=0.
- First cycle after reset release: ic_req_o=1, ic_addr_o=RESET_PC.
- A response in cycle t appears at the FIFO head (if empty) with id_valid_o=1 in cycle t+1.
- Peak throughput is one instruction per 2 cycles with a 1-cycle cache: accept, respond, request again.
- Redirect in cycle t: ic_addr_o=redirect_pc_i in t+1, with ic_req_o=1 only if no response is pending. id_valid_o=0 in t+1.
- Reset mid-request: state is lost, any later ic_rvalid_i is ignored until the next handshake. The cache must also be reset.
- With id_ready_i=0, at most FETCH_DEPTH entries are stored, then ic_req_o=0.

## Test plan
- Sequential fetch: reset, ic_ready_i=1, 1-cycle rvalid, rdata=pc^32'h1234 -> ID receives PCs bfc00000, bfc00004, bfc00008 in order with matching inst; fq_count_o peaks at 1.
- Backpressure: id_ready_i=0 -> exactly FETCH_DEPTH entries, ic_req_o=0, fq_count_o=4. Release -> FIFO order preserved and no entry lost.
- Redirect during wait: request accepted at bfc00010, redirect_pc_i=80000180 before rvalid -> stale response dropped; next ic_addr_o=80000180; first dequeued PC is 80000180.
- Redirect coinciding with handshake and dequeue -> queue empty, id_valid_o=0 next cycle, the accepted response is discarded.
- Misaligned: redirect_pc_i=bfc00002 -> no ic_req_o; one entry {pc=bfc00002, inst=0, adel=1}; fetch halted until redirect to bfc00380, which resumes normally.
- Async reset asserted in S_WAIT with 3 entries queued -> all outputs zero immediately; after release, fetch restarts at RESET_PC.
